// File: rtl/bp_be_pkg.sv
// Shared types for the backend page-table-walker arbiter: FSM states, owner encoding, grant pick.
package bp_be_pkg;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eIssue = 2'd1,
    eWait  = 2'd2
  } bp_be_ptw_arb_state_e;

  typedef enum logic {
    e_ptw_owner_i = 1'b0,
    e_ptw_owner_d = 1'b1
  } bp_be_ptw_owner_e;

  // D wins ties unless the I side has been passed over starve_limit_p times in a row.
  function automatic bp_be_ptw_owner_e ptw_arb_pick(input logic i_v, input logic d_v,
                                                     input logic starved);
    bp_be_ptw_owner_e owner;
    owner = e_ptw_owner_d;
    if (i_v && !d_v) begin
      owner = e_ptw_owner_i;
    end else if (i_v && d_v && starved) begin
      owner = e_ptw_owner_i;
    end
    return owner;
  endfunction

endpackage

// File: rtl/bp_be_ptw_arb_slot.sv
// One-entry miss holding register; set loads vaddr/store bit, clear wins over set.
// Zero latency to v_o after the capturing edge; the owner drops new requests while v_o is high.
module bp_be_ptw_arb_slot #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     set_i,
  input  logic                     clr_i,
  input  logic [vaddr_width_p-1:0] vaddr_i,
  input  logic                     store_i,
  output logic                     v_o,
  output logic [vaddr_width_p-1:0] vaddr_o,
  output logic                     store_o
);

  logic                     v_q;
  logic [vaddr_width_p-1:0] vaddr_q;
  logic                     store_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q     <= 1'b0;
      vaddr_q <= '0;
      store_q <= 1'b0;
    end else if (clr_i) begin
      v_q <= 1'b0;
    end else if (set_i) begin
      v_q     <= 1'b1;
      vaddr_q <= vaddr_i;
      store_q <= store_i;
    end
  end

  assign v_o     = v_q;
  assign vaddr_o = vaddr_q;
  assign store_o = store_q;

endmodule

// File: rtl/bp_be_ptw_arbiter.sv
// Shares one page-table walker between I-TLB and D-TLB misses; D priority with I anti-starvation.
// A miss accepted at an idle, non-busy edge issues in the very next cycle; ready_o low while a slot is held.
module bp_be_ptw_arbiter
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p  = 39,
  parameter int starve_limit_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     itlb_miss_v_i,
  input  logic [vaddr_width_p-1:0] itlb_miss_vaddr_i,
  output logic                     itlb_miss_ready_o,

  input  logic                     dtlb_miss_v_i,
  input  logic                     dtlb_miss_store_i,
  input  logic [vaddr_width_p-1:0] dtlb_miss_vaddr_i,
  output logic                     dtlb_miss_ready_o,

  input  logic                     flush_i,

  input  logic                     ptw_busy_i,
  output logic                     ptw_instr_miss_v_o,
  output logic                     ptw_load_miss_v_o,
  output logic                     ptw_store_miss_v_o,
  output logic [vaddr_width_p-1:0] ptw_vaddr_o,

  input  logic                     ptw_fill_v_i,
  input  logic                     ptw_instr_pf_i,
  input  logic                     ptw_load_pf_i,
  input  logic                     ptw_store_pf_i,

  output logic                     itlb_resp_v_o,
  output logic                     itlb_fill_v_o,
  output logic                     itlb_page_fault_o,

  output logic                     dtlb_resp_v_o,
  output logic                     dtlb_fill_v_o,
  output logic                     dtlb_load_pf_o,
  output logic                     dtlb_store_pf_o
);

  localparam int cnt_width_lp = $clog2(starve_limit_p + 1);

  bp_be_ptw_arb_state_e     state_q;
  bp_be_ptw_owner_e         owner_q;
  bp_be_ptw_owner_e         grant_owner;
  logic                     drop_q;
  logic [cnt_width_lp-1:0]  starve_cnt_q, starve_cnt_d;
  logic                     instr_miss_q, load_miss_q, store_miss_q;
  logic [vaddr_width_p-1:0] vaddr_q;

  logic                     i_v_lo, d_v_lo;
  logic [vaddr_width_p-1:0] i_vaddr_lo, d_vaddr_lo;
  logic                     i_store_lo, d_store_lo;
  logic                     i_set, d_set, i_clr, d_clr;
  logic                     i_elig, d_elig;
  logic [vaddr_width_p-1:0] i_vaddr_sel, d_vaddr_sel, sel_vaddr;
  logic                     d_store_sel, sel_store;
  logic                     starved, grant_d, issue_go;
  logic                     resp_v, resp_i, resp_d;

  assign resp_v = (state_q == eWait) & ptw_fill_v_i & ~drop_q;
  assign resp_i = resp_v & (owner_q == e_ptw_owner_i);
  assign resp_d = resp_v & (owner_q == e_ptw_owner_d);

  assign i_set = itlb_miss_v_i & ~i_v_lo & ~flush_i;
  assign d_set = dtlb_miss_v_i & ~d_v_lo & ~flush_i;
  assign i_clr = flush_i | resp_i;
  assign d_clr = flush_i | resp_d;

  bp_be_ptw_arb_slot #(.vaddr_width_p(vaddr_width_p)) i_slot (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .set_i     (i_set),
    .clr_i     (i_clr),
    .vaddr_i   (itlb_miss_vaddr_i),
    .store_i   (1'b0),
    .v_o       (i_v_lo),
    .vaddr_o   (i_vaddr_lo),
    .store_o   (i_store_lo)
  );

  bp_be_ptw_arb_slot #(.vaddr_width_p(vaddr_width_p)) d_slot (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .set_i     (d_set),
    .clr_i     (d_clr),
    .vaddr_i   (dtlb_miss_vaddr_i),
    .store_i   (dtlb_miss_store_i),
    .v_o       (d_v_lo),
    .vaddr_o   (d_vaddr_lo),
    .store_o   (d_store_lo)
  );

  // A miss being captured this edge competes alongside held ones, so a request can issue next cycle.
  assign i_elig      = i_v_lo | i_set;
  assign d_elig      = d_v_lo | d_set;
  assign i_vaddr_sel = i_v_lo ? i_vaddr_lo : itlb_miss_vaddr_i;
  assign d_vaddr_sel = d_v_lo ? d_vaddr_lo : dtlb_miss_vaddr_i;
  assign d_store_sel = d_v_lo ? d_store_lo : dtlb_miss_store_i;

  assign starved     = (starve_cnt_q == cnt_width_lp'(starve_limit_p));
  assign grant_owner = ptw_arb_pick(i_elig, d_elig, starved);
  assign grant_d     = (grant_owner == e_ptw_owner_d);
  assign sel_vaddr   = grant_d ? d_vaddr_sel : i_vaddr_sel;
  assign sel_store   = grant_d ? d_store_sel : i_store_lo;
  assign issue_go    = (state_q == eIdle) & ~flush_i & ~ptw_busy_i & (i_elig | d_elig);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_elig) begin
      starve_cnt_d = '0;
    end else if (issue_go) begin
      if (!grant_d) begin
        starve_cnt_d = '0;
      end else if (!starved) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= eIdle;
      owner_q      <= e_ptw_owner_i;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
      instr_miss_q <= 1'b0;
      load_miss_q  <= 1'b0;
      store_miss_q <= 1'b0;
      vaddr_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      instr_miss_q <= 1'b0;
      load_miss_q  <= 1'b0;
      store_miss_q <= 1'b0;
      case (state_q)
        eIdle: begin
          if (issue_go) begin
            state_q      <= eIssue;
            owner_q      <= grant_owner;
            instr_miss_q <= ~grant_d;
            load_miss_q  <= grant_d & ~sel_store;
            store_miss_q <= grant_d & sel_store;
            vaddr_q      <= sel_vaddr;
          end
        end
        eIssue: begin
          state_q <= eWait;
          if (flush_i) drop_q <= 1'b1;
        end
        eWait: begin
          // A flushed walk still has to drain; drop_q masks its result.
          if (ptw_fill_v_i) begin
            state_q <= eIdle;
            drop_q  <= 1'b0;
          end else if (flush_i) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= eIdle;
      endcase
    end
  end

  assign itlb_miss_ready_o  = ~i_v_lo;
  assign dtlb_miss_ready_o  = ~d_v_lo;

  assign ptw_instr_miss_v_o = instr_miss_q;
  assign ptw_load_miss_v_o  = load_miss_q;
  assign ptw_store_miss_v_o = store_miss_q;
  assign ptw_vaddr_o        = vaddr_q;

  assign itlb_resp_v_o      = resp_i;
  assign itlb_page_fault_o  = resp_i & ptw_instr_pf_i;
  assign itlb_fill_v_o      = resp_i & ~ptw_instr_pf_i;

  assign dtlb_resp_v_o      = resp_d;
  assign dtlb_load_pf_o     = resp_d & ptw_load_pf_i;
  assign dtlb_store_pf_o    = resp_d & ptw_store_pf_i;
  assign dtlb_fill_v_o      = resp_d & ~(ptw_load_pf_i | ptw_store_pf_i);

  fill_only_in_wait: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ptw_fill_v_i |-> (state_q == eWait));

endmodule

// File: tb/tb_bp_be_ptw_arbiter.sv
// Directed bench for the PTW arbiter: issue latency, priority/starvation, faults, flush, busy, reset.
module tb_bp_be_ptw_arbiter;
  import bp_be_pkg::*;

  localparam int VW = 39;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          itlb_miss_v_i;
  logic [VW-1:0] itlb_miss_vaddr_i;
  logic          itlb_miss_ready_o;
  logic          dtlb_miss_v_i;
  logic          dtlb_miss_store_i;
  logic [VW-1:0] dtlb_miss_vaddr_i;
  logic          dtlb_miss_ready_o;
  logic          flush_i;
  logic          ptw_busy_i;
  logic          ptw_instr_miss_v_o, ptw_load_miss_v_o, ptw_store_miss_v_o;
  logic [VW-1:0] ptw_vaddr_o;
  logic          ptw_fill_v_i;
  logic          ptw_instr_pf_i, ptw_load_pf_i, ptw_store_pf_i;
  logic          itlb_resp_v_o, itlb_fill_v_o, itlb_page_fault_o;
  logic          dtlb_resp_v_o, dtlb_fill_v_o, dtlb_load_pf_o, dtlb_store_pf_o;

  int total = 0;
  int bad   = 0;

  logic [2:0] pkt;
  logic [6:0] resp_bus;
  logic [9:0] all_v;
  assign pkt      = {ptw_instr_miss_v_o, ptw_load_miss_v_o, ptw_store_miss_v_o};
  assign resp_bus = {itlb_resp_v_o, itlb_fill_v_o, itlb_page_fault_o,
                     dtlb_resp_v_o, dtlb_fill_v_o, dtlb_load_pf_o, dtlb_store_pf_o};
  assign all_v    = {pkt, resp_bus};

  always #5 clk_i = ~clk_i;

  bp_be_ptw_arbiter #(.vaddr_width_p(VW), .starve_limit_p(4)) dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .itlb_miss_v_i      (itlb_miss_v_i),
    .itlb_miss_vaddr_i  (itlb_miss_vaddr_i),
    .itlb_miss_ready_o  (itlb_miss_ready_o),
    .dtlb_miss_v_i      (dtlb_miss_v_i),
    .dtlb_miss_store_i  (dtlb_miss_store_i),
    .dtlb_miss_vaddr_i  (dtlb_miss_vaddr_i),
    .dtlb_miss_ready_o  (dtlb_miss_ready_o),
    .flush_i            (flush_i),
    .ptw_busy_i         (ptw_busy_i),
    .ptw_instr_miss_v_o (ptw_instr_miss_v_o),
    .ptw_load_miss_v_o  (ptw_load_miss_v_o),
    .ptw_store_miss_v_o (ptw_store_miss_v_o),
    .ptw_vaddr_o        (ptw_vaddr_o),
    .ptw_fill_v_i       (ptw_fill_v_i),
    .ptw_instr_pf_i     (ptw_instr_pf_i),
    .ptw_load_pf_i      (ptw_load_pf_i),
    .ptw_store_pf_i     (ptw_store_pf_i),
    .itlb_resp_v_o      (itlb_resp_v_o),
    .itlb_fill_v_o      (itlb_fill_v_o),
    .itlb_page_fault_o  (itlb_page_fault_o),
    .dtlb_resp_v_o      (dtlb_resp_v_o),
    .dtlb_fill_v_o      (dtlb_fill_v_o),
    .dtlb_load_pf_o     (dtlb_load_pf_o),
    .dtlb_store_pf_o    (dtlb_store_pf_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Bounded wait for a packet; a timeout shows up as a packet mismatch.
  task automatic wait_issue(input string tag, input logic [2:0] exp_pkt, input logic [VW-1:0] exp_va);
    int n;
    n = 0;
    while (pkt == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_pkt"}, 64'(pkt), 64'(exp_pkt));
    check({tag, "_va"}, 64'(ptw_vaddr_o), 64'(exp_va));
  endtask

  initial begin
    logic [VW-1:0] dva [0:4];
    logic [VW-1:0] iva;

    reset_n_i = 1'b0;
    itlb_miss_v_i = 1'b0; itlb_miss_vaddr_i = '0;
    dtlb_miss_v_i = 1'b0; dtlb_miss_store_i = 1'b0; dtlb_miss_vaddr_i = '0;
    flush_i = 1'b0; ptw_busy_i = 1'b0;
    ptw_fill_v_i = 1'b0; ptw_instr_pf_i = 1'b0; ptw_load_pf_i = 1'b0; ptw_store_pf_i = 1'b0;

    // reset state
    tick(); tick();
    check("rst_outs", 64'(all_v), 64'h0);
    check("rst_ready", 64'({itlb_miss_ready_o, dtlb_miss_ready_o}), 64'h3);
    check("rst_state", 64'(dut.state_q), 64'(eIdle));
    reset_n_i = 1'b1;
    tick();

    // single I miss, walker idle
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h40_0000_1000;
    tick();
    itlb_miss_v_i = 1'b0;
    check("i_issue_pkt", 64'(pkt), 64'h4);
    check("i_issue_va", 64'(ptw_vaddr_o), 64'h40_0000_1000);
    check("i_ready_held", 64'(itlb_miss_ready_o), 64'h0);
    tick();
    check("i_pulse_once", 64'(pkt), 64'h0);
    ptw_fill_v_i = 1'b1; #1;
    check("i_resp", 64'(resp_bus), 64'b110_0000);
    tick();
    ptw_fill_v_i = 1'b0;
    check("i_ready_back", 64'(itlb_miss_ready_o), 64'h1);
    check("i_resp_gone", 64'(resp_bus), 64'h0);

    // flush and request together: request dropped
    flush_i = 1'b1; itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h1234;
    tick();
    flush_i = 1'b0; itlb_miss_v_i = 1'b0;
    check("flushreq_ready", 64'(itlb_miss_ready_o), 64'h1);
    check("flushreq_pkt", 64'(pkt), 64'h0);
    tick();
    check("flushreq_pkt2", 64'(pkt), 64'h0);

    // starvation: D granted 4 times, then I
    iva = 39'h1_1000;
    for (int k = 0; k < 5; k++) dva[k] = 39'h2_0000 + VW'(k * 4096);
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = iva;
    dtlb_miss_v_i = 1'b1; dtlb_miss_store_i = 1'b0; dtlb_miss_vaddr_i = dva[0];
    tick();
    itlb_miss_v_i = 1'b0; dtlb_miss_v_i = 1'b0;
    for (int g = 0; g < 5; g++) begin
      if (g < 4) wait_issue($sformatf("starve_g%0d", g), 3'b010, dva[g]);
      else       wait_issue("starve_g4", 3'b100, iva);
      if (g == 3) check("starve_cnt_sat", 64'(dut.starve_cnt_q), 64'd4);
      if (g == 4) check("starve_cnt_clr", 64'(dut.starve_cnt_q), 64'd0);
      tick();
      ptw_fill_v_i = 1'b1; #1;
      if (g < 4) check($sformatf("starve_resp%0d", g), 64'(resp_bus), 64'b000_1100);
      else       check("starve_resp4", 64'(resp_bus), 64'b110_0000);
      tick();
      ptw_fill_v_i = 1'b0;
      if (g < 4) begin
        dtlb_miss_v_i = 1'b1; dtlb_miss_vaddr_i = dva[g+1];
        tick();
        dtlb_miss_v_i = 1'b0;
      end
    end
    wait_issue("starve_tail", 3'b010, dva[4]);
    tick();
    ptw_fill_v_i = 1'b1; #1;
    check("starve_tail_resp", 64'(resp_bus), 64'b000_1100);
    tick();
    ptw_fill_v_i = 1'b0;

    // D store miss returning a store page fault
    dtlb_miss_v_i = 1'b1; dtlb_miss_store_i = 1'b1; dtlb_miss_vaddr_i = 39'h3_3000;
    tick();
    dtlb_miss_v_i = 1'b0; dtlb_miss_store_i = 1'b0;
    check("st_pkt", 64'(pkt), 64'h1);
    check("st_va", 64'(ptw_vaddr_o), 64'h3_3000);
    tick();
    ptw_fill_v_i = 1'b1; ptw_store_pf_i = 1'b1; #1;
    check("st_pf_resp", 64'(resp_bus), 64'b000_1001);
    tick();
    ptw_fill_v_i = 1'b0; ptw_store_pf_i = 1'b0;
    check("st_after", 64'(all_v), 64'h0);

    // flush during eWait: drained fill is suppressed, new D miss waits for eIdle
    dtlb_miss_v_i = 1'b1; dtlb_miss_vaddr_i = 39'h7_0000_3000;
    tick();
    dtlb_miss_v_i = 1'b0;
    check("fl_pkt", 64'(pkt), 64'h2);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("fl_ready", 64'(dtlb_miss_ready_o), 64'h1);
    dtlb_miss_v_i = 1'b1; dtlb_miss_vaddr_i = 39'h4_4000;
    tick();
    dtlb_miss_v_i = 1'b0;
    check("fl_held", 64'({pkt, dtlb_miss_ready_o}), 64'h0);
    tick();
    ptw_fill_v_i = 1'b1; #1;
    check("fl_suppress", 64'(all_v), 64'h0);
    tick();
    ptw_fill_v_i = 1'b0;
    check("fl_idle", 64'(dut.state_q), 64'(eIdle));
    check("fl_no_early", 64'(pkt), 64'h0);
    tick();
    check("fl_reissue_pkt", 64'(pkt), 64'h2);
    check("fl_reissue_va", 64'(ptw_vaddr_o), 64'h4_4000);
    tick();
    ptw_fill_v_i = 1'b1; #1;
    check("fl_resp", 64'(resp_bus), 64'b000_1100);
    tick();
    ptw_fill_v_i = 1'b0;

    // walker busy holds off issue
    ptw_busy_i = 1'b1;
    itlb_miss_v_i = 1'b1; itlb_miss_vaddr_i = 39'h5_5000;
    tick();
    itlb_miss_v_i = 1'b0;
    check("busy_hold0", 64'(pkt), 64'h0);
    tick();
    check("busy_hold1", 64'(pkt), 64'h0);
    ptw_busy_i = 1'b0;
    tick();
    check("busy_issue_pkt", 64'(pkt), 64'h4);
    check("busy_issue_va", 64'(ptw_vaddr_o), 64'h5_5000);

    // reset while waiting on the walker
    tick();
    check("rw_in_wait", 64'(dut.state_q), 64'(eWait));
    reset_n_i = 1'b0;
    tick();
    check("rw_outs", 64'(all_v), 64'h0);
    check("rw_ready", 64'({itlb_miss_ready_o, dtlb_miss_ready_o}), 64'h3);
    check("rw_state", 64'(dut.state_q), 64'(eIdle));
    reset_n_i = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_be_ptw_arbiter.md
Name: bp_be_ptw_arbiter

Overview:
- Shares the single page-table walker between the I-TLB miss path and the D-TLB miss path.
- Buffers one pending miss per requester and picks one. Grant policy: fixed D-side priority, with an anti-starvation counter that forces an I-side grant.
- Issues a one-cycle miss packet to the walker, tracks the walk to completion and routes the fill or fault back to the owning requester.
- Handles flushes that arrive mid-walk. Sits in bp_be_calculator between the TLBs and the walker.

Parameters:
- vaddr_width_p, 39, virtual address width.
- starve_limit_p, 4, consecutive D grants allowed while an I miss waits; must be ≥1.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, synchronous, active-low
- itlb_miss_v_i  in  1  I-TLB miss request valid
- itlb_miss_vaddr_i  in  vaddr_width_p  faulting fetch vaddr
- itlb_miss_ready_o  out  1  I slot empty
- dtlb_miss_v_i  in  1  D-TLB miss request valid
- dtlb_miss_store_i  in  1  1 = store miss, 0 = load miss
- dtlb_miss_vaddr_i  in  vaddr_width_p  faulting data vaddr
- dtlb_miss_ready_o  out  1  D slot empty
- flush_i  in  1  discard all pending and in-flight misses
- ptw_busy_i  in  1  walker busy
- ptw_instr_miss_v_o / ptw_load_miss_v_o / ptw_store_miss_v_o  out  1 each  one-hot miss packet type
- ptw_vaddr_o  out  vaddr_width_p  miss packet vaddr
- ptw_fill_v_i  in  1  walker fill/fault valid
- ptw_instr_pf_i / ptw_load_pf_i / ptw_store_pf_i  in  1 each  walker fault flags
- itlb_resp_v_o  out  1  walk for I owner done
- itlb_fill_v_o  out  1  write I-TLB with walker entry
- itlb_page_fault_o  out  1  instruction page fault
- dtlb_resp_v_o  out  1  walk for D owner done
- dtlb_fill_v_o  out  1  write D-TLB with walker entry
- dtlb_load_pf_o / dtlb_store_pf_o  out  1 each  data page faults

Behaviour:
- Reset (reset_n_i=0 at posedge):
  - State goes to eIdle.
  - Both slots are emptied and drop_r, owner_r and starve_cnt are cleared.
  - All *_v_o and pf outputs are 0; both ready outputs are 1 after reset.
  - Reset mid-walk abandons the walk; the walker is reset by the same domain.
- Accept:
  - A request is captured when miss_v_i & ready_o & ~flush_i.
  - A slot holds vaddr plus the store bit (D only). ready_o = slot empty.
  - A slot frees the cycle after its response or a flush, so back-to-back accept resumes next cycle.
- States:
  - eIdle: stays in eIdle when flush_i=1. Otherwise, if any slot is full and ptw_busy_i=0, choose an owner and go to eIssue.
  - eIssue: drive exactly one packet-type bit plus ptw_vaddr_o for this one cycle. Move to eWait unconditionally. ptw_*_miss_v_o are 0 in every other state.
  - eWait: hold until ptw_fill_v_i, then go to eIdle.
- Selection:
  - If only one slot is full, grant it.
  - If both are full, grant D unless starve_cnt == starve_limit_p, in which case grant I.
  - starve_cnt increments on a D grant while the I slot is full, saturating at starve_limit_p. It clears on any I grant or when the I slot is empty.
  - owner_r is registered at the eIdle→eIssue transition.
- Response (combinational, in the fill cycle):
  - Qualifier: state==eWait & ptw_fill_v_i & ~drop_r.
  - Owner I:
    - itlb_resp_v_o=1.
    - itlb_page_fault_o=ptw_instr_pf_i.
    - itlb_fill_v_o = ~ptw_instr_pf_i.
  - Owner D:
    - dtlb_resp_v_o=1.
    - pf flags are passed through.
    - dtlb_fill_v_o = ~(load_pf|store_pf).
  - The owner's slot clears at that edge.
- Flush:
  - Both slots clear the next edge.
  - If flush arrives in eIssue or eWait, set drop_r. The walk still runs to ptw_fill_v_i, but its fill/fault is suppressed (all resp outputs 0). drop_r clears on leaving eWait.
  - A new request in the slot during drop is legal and is issued only after eIdle.
- Simultaneous events:
  - Fill and new same-owner request in one cycle: the new request is not accepted, because ready is 0 while the slot is full.
  - Flush and request in one cycle: the request is ignored.
  - ptw_fill_v_i outside eWait is ignored and flags an assertion.
- Latency: with the walker idle, the request is accepted at edge N, eIssue runs in cycle N+1, and the walker sees the miss in cycle N+1.

Decomposition:
- bp_be_pkg gets:
  - the state enum bp_be_ptw_arb_state_e {eIdle, eIssue, eWait};
  - owner encoding e_ptw_owner_i/e_ptw_owner_d.
- The two request slots are identical bsg_dff_reset_en-style holding registers. A local sub-module bp_be_ptw_arb_slot (valid, vaddr, store bit, set/clear) is instantiated twice.
- The starvation counter is an inline saturating counter.

Test Plan:
- I miss only, vaddr 0x40_0000_1000, walker idle:
  - ptw_instr_miss_v_o pulses exactly 1 cycle.
  - After the fill with pf=0: itlb_resp_v_o=1 and itlb_fill_v_o=1 in the same cycle, and itlb_miss_ready_o=1 the next cycle.
- I and D misses in the same cycle, starve_limit_p=4, D re-requested immediately after each response:
  - D is granted 4 times, then I is granted.
  - starve_cnt reads 0 after the I grant.
- D store miss, walker returns ptw_store_pf_i=1:
  - dtlb_resp_v_o=1, dtlb_store_pf_o=1, dtlb_fill_v_o=0.
  - No I-side output toggles.
- flush_i in the eWait cycle:
  - The fill 3 cycles later produces no resp outputs.
  - A D miss accepted after the flush issues only after eIdle.
- ptw_busy_i held 1 with an I request pending: no issue occurs; issue happens the cycle after busy drops.
- reset_n_i=0 asserted while in eWait: at the next edge all outputs are 0, both ready outputs are 1, and state is eIdle.
